exec_div_ctrl: RTL and testbench

- Issue/retire controller for the execute-stage multi-cycle divider.
- Accepts DIV/DIVU/REM/REMU from the ID/EX register and fires the divider. Holds the pipeline stalled until the result retires, then buffers the result to EX/MEM with a valid/ready handshake.
- Resolves divide-by-zero itself in one cycle, RISC-V semantics, without starting the divider.

---
 rtl/exec_div_ctrl.sv | 124 ++++++++++++
 tb/tb_exec_div_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_div_ctrl.sv
// Issue/retire controller for the execute-stage multi-cycle divider: fires the divider,
// stalls the pipeline while it runs and hands the result to EX/MEM over valid/ready.

package exec_div_pkg;
  typedef logic [3:0] aluop_t;
  typedef logic [4:0] alucontrol_t;

  localparam aluop_t      ALUOP_DIV = 4'd9;
  localparam alucontrol_t ALU_DIV   = 5'd20;
  localparam alucontrol_t ALU_DIVU  = 5'd21;
  localparam alucontrol_t ALU_REM   = 5'd22;
  localparam alucontrol_t ALU_REMU  = 5'd23;
endpackage

module exec_div_ctrl
  import exec_div_pkg::*;
#(
  parameter int unsigned SHIFT_COUNT = 32,
  parameter int unsigned TIMEOUT     = 40
) (
  input  logic        clk,
  input  logic        start,
  input  logic        flush,
  input  logic        in_valid,
  input  aluop_t      aluop,
  input  alucontrol_t alucontrol,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [4:0]  in_rd,
  output logic        div_fire,
  output alucontrol_t div_alucontrol,
  input  logic        div_valid,
  input  logic [31:0] divresult,
  output logic        ex_stall,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,
  output logic        div_timeout
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StHold} state_t;

  state_t          state_q;
  alucontrol_t     alu_q;
  logic [CntW-1:0] cnt_q;

  logic req, dz, accept, is_rem;

  assign req    = in_valid && (aluop == ALUOP_DIV);
  assign dz     = (in_b == 32'd0);
  assign accept = (state_q == StIdle) && req && !flush;
  assign is_rem = (alucontrol == ALU_REM) || (alucontrol == ALU_REMU);

  assign div_fire = accept && !dz;
  // Live op on the fire edge for sign decode, latched op afterwards for the output mux.
  assign div_alucontrol = (state_q == StIdle) ? alucontrol : alu_q;
  // Dropping the stall on the handshake edge lets the next instruction enter EX right away.
  assign ex_stall = req && !((state_q == StHold) && out_ready);

  always_ff @(posedge clk) begin
    if (!start) begin
      state_q     <= StIdle;
      out_valid   <= 1'b0;
      out_result  <= 32'd0;
      out_rd      <= 5'd0;
      div_timeout <= 1'b0;
      alu_q       <= ALU_DIV;
      cnt_q       <= '0;
    end else if (flush) begin
      state_q   <= StIdle;
      out_valid <= 1'b0;
      cnt_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req) begin
            alu_q  <= alucontrol;
            out_rd <= in_rd;
            cnt_q  <= '0;
            if (dz) begin
              // Divide-by-zero resolved locally: all-ones quotient, dividend remainder.
              out_result <= is_rem ? in_a : 32'hFFFF_FFFF;
              out_valid  <= 1'b1;
              state_q    <= StHold;
            end else begin
              state_q <= StBusy;
            end
          end
        end
        StBusy: begin
          if (div_valid) begin
            out_result <= divresult;
            out_valid  <= 1'b1;
            cnt_q      <= '0;
            state_q    <= StHold;
          end else if (cnt_q == CntLast) begin
            div_timeout <= 1'b1;
            out_result  <= 32'd0;
            out_valid   <= 1'b1;
            cnt_q       <= '0;
            state_q     <= StHold;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StHold: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // The watchdog must outlast a normal divide.
  timeout_gt_shift: assert property (@(posedge clk) TIMEOUT > SHIFT_COUNT + 1);

endmodule

// File: tb/tb_exec_div_ctrl.sv
// Self-checking bench for exec_div_ctrl: divider stub, transaction-level reference model,
// directed scenarios with literal expectations, then randomized traffic.

module tb_exec_div_ctrl;
  import exec_div_pkg::*;

  localparam int unsigned SHIFT_COUNT = 32;
  localparam int unsigned TIMEOUT     = 40;

  logic        clk = 1'b0;
  logic        start, flush, in_valid, div_valid, out_ready;
  aluop_t      aluop;
  alucontrol_t alucontrol, div_alucontrol;
  logic [31:0] in_a, in_b, divresult, out_result;
  logic [4:0]  in_rd, out_rd;
  logic        div_fire, ex_stall, out_valid, div_timeout;

  exec_div_ctrl #(.SHIFT_COUNT(SHIFT_COUNT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .start(start), .flush(flush), .in_valid(in_valid), .aluop(aluop),
    .alucontrol(alucontrol), .in_a(in_a), .in_b(in_b), .in_rd(in_rd), .div_fire(div_fire),
    .div_alucontrol(div_alucontrol), .div_valid(div_valid), .divresult(divresult),
    .ex_stall(ex_stall), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .div_timeout(div_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: a pending divide with its age, or a result waiting to retire.
  bit          m_known = 1'b0, m_busy = 1'b0, m_hold = 1'b0, m_to = 1'b0;
  int          m_age = 0;
  alucontrol_t m_op;
  logic [31:0] m_a, m_b, m_res;
  logic [4:0]  m_rd;

  // Divider stub.
  int          st_cnt = -1;
  logic [31:0] st_res;
  bit          withhold = 1'b0, spurious_en = 1'b0;

  // Outputs sampled mid-cycle by step().
  logic        s_fire, s_valid, s_stall, s_to;
  logic [31:0] s_res;
  logic [4:0]  s_rd;

  alucontrol_t ops [4];

  function automatic logic [31:0] ref_div(alucontrol_t op, logic [31:0] a, logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return (op == ALU_REM || op == ALU_REMU) ? a : 32'hFFFF_FFFF;
    case (op)
      ALU_DIVU: return a / b;
      ALU_REMU: return a % b;
      ALU_DIV:  return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : 32'(sa / sb);
      ALU_REM:  return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(sa % sb);
      default:  return 32'd0;
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: inputs already driven; compare at negedge, advance model, drive stub.
  task automatic step();
    bit req, idle, dz, acc;
    #4;
    s_fire  = div_fire;
    s_valid = out_valid;
    s_stall = ex_stall;
    s_to    = div_timeout;
    s_res   = out_result;
    s_rd    = out_rd;
    req  = in_valid && (aluop == ALUOP_DIV);
    idle = !m_busy && !m_hold;
    dz   = (in_b == 32'd0);
    acc  = idle && req && !flush;
    if (m_known) begin
      chk("out_valid", 32'(out_valid), 32'(m_hold));
      chk("div_fire", 32'(div_fire), 32'(acc && !dz));
      chk("div_alucontrol", 32'(div_alucontrol), 32'(idle ? alucontrol : m_op));
      chk("ex_stall", 32'(ex_stall), 32'(req && !(m_hold && out_ready)));
      chk("div_timeout", 32'(div_timeout), 32'(m_to));
      if (m_hold) begin
        chk("out_result", out_result, m_res);
        chk("out_rd", 32'(out_rd), 32'(m_rd));
      end
    end
    if (div_fire === 1'b1) begin
      st_cnt = SHIFT_COUNT + 1;
      st_res = ref_div(div_alucontrol, in_a, in_b);
    end
    if (!start) begin
      m_known = 1'b1; m_busy = 1'b0; m_hold = 1'b0; m_to = 1'b0;
      m_res = 32'd0; m_rd = 5'd0; m_op = ALU_DIV;
    end else if (flush) begin
      m_busy = 1'b0;
      m_hold = 1'b0;
    end else if (acc) begin
      m_op = alucontrol;
      m_rd = in_rd;
      if (dz) begin
        m_hold = 1'b1;
        m_res  = ref_div(alucontrol, in_a, in_b);
      end else begin
        m_busy = 1'b1; m_age = 0; m_a = in_a; m_b = in_b;
      end
    end else if (m_busy) begin
      m_age++;
      if (div_valid) begin
        m_busy = 1'b0; m_hold = 1'b1; m_res = ref_div(m_op, m_a, m_b);
      end else if (m_age == int'(TIMEOUT)) begin
        m_busy = 1'b0; m_hold = 1'b1; m_to = 1'b1; m_res = 32'd0;
      end
    end else if (m_hold && out_ready) begin
      m_hold = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (st_cnt >= 0) st_cnt--;
    if (st_cnt == 0 && !withhold) begin
      div_valid = 1'b1;
      divresult = st_res;
    end else begin
      div_valid = spurious_en && !m_busy && ($urandom_range(0, 15) == 0);
      divresult = $urandom;
    end
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; aluop = 4'd0; flush = 1'b0; out_ready = 1'b1;
  endtask

  // Issue one divide and hold it in EX until it retires; hold_cycles of back-pressure.
  task automatic run_op(input alucontrol_t op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int hold_cycles,
                        output logic [31:0] res, output logic [4:0] rdo,
                        output int lat, output int fires);
    int k;
    in_valid = 1'b1; aluop = ALUOP_DIV; alucontrol = op; in_a = a; in_b = b; in_rd = rd;
    flush = 1'b0;
    out_ready = (hold_cycles == 0);
    lat = -1; fires = 0; k = 0;
    res = 32'd0; rdo = 5'd0;
    while (lat < 0 && k < 100) begin
      step();
      if (s_fire) fires++;
      if (s_valid) lat = k;
      k++;
    end
    if (lat < 0) begin
      checks++;
      failures++;
      $display("FAIL op_wait cyc=%0d got=no out_valid expected=out_valid within 100 cycles", cyc);
    end else begin
      res = s_res;
      rdo = s_rd;
      for (int i = 0; i < hold_cycles; i++) begin
        step();
        chk("bp_valid", 32'(s_valid), 32'd1);
        chk("bp_result", s_res, res);
        chk("bp_stall", 32'(s_stall), 32'd1);
      end
      if (hold_cycles > 0) begin
        out_ready = 1'b1;
        step();
      end
    end
    in_valid = 1'b0;
  endtask

  logic [31:0] r;
  logic [4:0]  rdv;
  int          lat, fires, vcnt;

  initial begin
    ops[0] = ALU_DIV; ops[1] = ALU_DIVU; ops[2] = ALU_REM; ops[3] = ALU_REMU;
    start = 1'b0; idle_inputs(); alucontrol = ALU_DIVU;
    in_a = 32'd0; in_b = 32'd1; in_rd = 5'd0; div_valid = 1'b0; divresult = 32'd0;
    @(posedge clk);
    #1;

    // Reset state.
    step();
    step();
    chk("rst_valid", 32'(s_valid), 32'd0);
    chk("rst_result", s_res, 32'd0);
    chk("rst_rd", 32'(s_rd), 32'd0);
    chk("rst_timeout", 32'(s_to), 32'd0);
    start = 1'b1;
    step();

    // DIVU 100/7 with out_ready high.
    run_op(ALU_DIVU, 32'd100, 32'd7, 5'd5, 0, r, rdv, lat, fires);
    chk("divu_res", r, 32'd14);
    chk("divu_rd", 32'(rdv), 32'd5);
    chk("divu_lat", 32'(lat), 32'd34);
    chk("divu_fires", 32'(fires), 32'd1);
    step();
    chk("divu_idle", 32'(s_valid), 32'd0);

    // Signed results, back to back.
    run_op(ALU_DIV, 32'hFFFF_FFF9, 32'd2, 5'd1, 0, r, rdv, lat, fires);
    chk("div_neg", r, 32'hFFFF_FFFD);
    run_op(ALU_REM, 32'hFFFF_FFF9, 32'd2, 5'd2, 0, r, rdv, lat, fires);
    chk("rem_neg", r, 32'hFFFF_FFFF);
    run_op(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 0, r, rdv, lat, fires);
    chk("div_ovf", r, 32'h8000_0000);
    run_op(ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 0, r, rdv, lat, fires);
    chk("rem_ovf", r, 32'd0);

    // Divide by zero.
    run_op(ALU_DIV, 32'hFFFF_FFFB, 32'd0, 5'd6, 0, r, rdv, lat, fires);
    chk("dz_div_res", r, 32'hFFFF_FFFF);
    chk("dz_div_lat", 32'(lat), 32'd1);
    chk("dz_div_fires", 32'(fires), 32'd0);
    run_op(ALU_REMU, 32'h1234, 32'd0, 5'd7, 0, r, rdv, lat, fires);
    chk("dz_remu_res", r, 32'h1234);
    chk("dz_remu_fires", 32'(fires), 32'd0);

    // Back-pressure, then a back-to-back DIVU 9/3.
    run_op(ALU_DIVU, 32'd81, 32'd9, 5'd8, 5, r, rdv, lat, fires);
    chk("bp_res", r, 32'd9);
    run_op(ALU_DIVU, 32'd9, 32'd3, 5'd9, 0, r, rdv, lat, fires);
    chk("b2b_res", r, 32'd3);
    chk("b2b_lat", 32'(lat), 32'd34);

    // Flush at cycle 10 of the divide; flush also beats a fresh accept.
    in_valid = 1'b1; aluop = ALUOP_DIV; alucontrol = ALU_DIVU; in_a = 32'd7; in_b = 32'd1;
    in_rd = 5'd10;
    repeat (10) step();
    flush = 1'b1;
    step();
    step();
    chk("flush_no_fire", 32'(s_fire), 32'd0);
    flush = 1'b0;
    in_valid = 1'b0;
    vcnt = 0;
    repeat (40) begin
      step();
      if (s_valid) vcnt++;
    end
    chk("flush_no_valid", 32'(vcnt), 32'd0);
    run_op(ALU_DIVU, 32'd50, 32'd5, 5'd11, 0, r, rdv, lat, fires);
    chk("post_flush_res", r, 32'd10);
    chk("post_flush_lat", 32'(lat), 32'd34);

    // Watchdog: divider never answers.
    withhold = 1'b1;
    run_op(ALU_DIVU, 32'd20, 32'd4, 5'd12, 0, r, rdv, lat, fires);
    withhold = 1'b0;
    chk("wd_res", r, 32'd0);
    chk("wd_lat", 32'(lat), 32'(TIMEOUT + 1));
    chk("wd_flag", 32'(s_to), 32'd1);
    step();
    chk("wd_sticky", 32'(s_to), 32'd1);

    // Reset in the middle of a divide.
    in_valid = 1'b1; aluop = ALUOP_DIV; alucontrol = ALU_DIVU; in_a = 32'd1000;
    in_b = 32'd10; in_rd = 5'd13;
    repeat (10) step();
    start = 1'b0;
    step();
    start = 1'b1;
    in_valid = 1'b0;
    step();
    chk("mid_rst_valid", 32'(s_valid), 32'd0);
    chk("mid_rst_result", s_res, 32'd0);
    chk("mid_rst_rd", 32'(s_rd), 32'd0);
    chk("mid_rst_timeout", 32'(s_to), 32'd0);
    chk("mid_rst_stall", 32'(s_stall), 32'd0);

    // Randomized traffic against the model.
    spurious_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      start      = ($urandom_range(0, 199) != 0);
      flush      = ($urandom_range(0, 59) == 0);
      in_valid   = ($urandom_range(0, 1) == 1);
      aluop      = ($urandom_range(0, 3) != 0) ? ALUOP_DIV : aluop_t'($urandom_range(0, 3));
      alucontrol = ops[$urandom_range(0, 3)];
      in_rd      = 5'($urandom);
      out_ready  = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 7))
        0: begin in_a = $urandom; in_b = 32'd0; end
        1: begin in_a = 32'h8000_0000; in_b = 32'hFFFF_FFFF; end
        2: begin in_a = 32'($urandom_range(0, 500)); in_b = 32'($urandom_range(1, 20)); end
        default: begin in_a = $urandom; in_b = $urandom | 32'd1; end
      endcase
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
